// File: rtl/mdu_ctrl.sv
// Multi-cycle multiply/divide sequencer with HI/LO registers for the execute stage.
// Radix-2 shift-add multiply and restoring divide on operand magnitudes, sign-corrected in DONE.
module mdu_ctrl #(
    parameter int W = 32
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_start,
    input  logic [5:0]   i_funct,
    input  logic [W-1:0] i_a,
    input  logic [W-1:0] i_b,
    input  logic         i_flush,
    output logic         o_stall,
    output logic         o_busy,
    output logic [W-1:0] o_hi,
    output logic [W-1:0] o_lo
);

    localparam int CW = $clog2(W);

    localparam logic [5:0] F_MULT  = 6'b011000;
    localparam logic [5:0] F_MULTU = 6'b011001;
    localparam logic [5:0] F_DIV   = 6'b011010;
    localparam logic [5:0] F_DIVU  = 6'b011011;
    localparam logic [5:0] F_MTHI  = 6'b010001;
    localparam logic [5:0] F_MTLO  = 6'b010011;

    typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

    state_t          r_state;
    logic            r_busy;
    logic [CW-1:0]   r_cnt;
    logic [W-1:0]    r_hi;
    logic [W-1:0]    r_lo;
    logic [2*W-1:0]  r_mcand;
    logic [W-1:0]    r_opB;
    logic [2*W-1:0]  r_acc;
    logic            r_qSign;
    logic            r_rSign;
    logic            r_isDiv;
    logic            r_divZero;

    logic            w_isMul;
    logic            w_isDiv;
    logic            w_signed;
    logic            w_aNeg;
    logic            w_bNeg;
    logic [W-1:0]    w_aMag;
    logic [W-1:0]    w_bMag;
    logic            w_cntLast;
    logic [W:0]      w_remShift;
    logic [W:0]      w_diff;
    logic            w_fits;
    logic [2*W-1:0]  w_prodNeg;
    logic [W-1:0]    w_quotNeg;
    logic [W-1:0]    w_remNeg;

    assign w_isMul   = (i_funct == F_MULT) | (i_funct == F_MULTU);
    assign w_isDiv   = (i_funct == F_DIV)  | (i_funct == F_DIVU);
    assign w_signed  = (i_funct == F_MULT) | (i_funct == F_DIV);
    assign w_aNeg    = w_signed & i_a[W-1];
    assign w_bNeg    = w_signed & i_b[W-1];
    assign w_aMag    = w_aNeg ? -i_a : i_a;
    assign w_bMag    = w_bNeg ? -i_b : i_b;
    assign w_cntLast = (r_cnt == CW'(W-1));

    // Divide keeps the partial remainder in r_acc's upper half and the dividend/quotient in the lower half.
    assign w_remShift = {r_acc[2*W-1:W], r_acc[W-1]};
    assign w_diff     = w_remShift - {1'b0, r_opB};
    assign w_fits     = ~w_diff[W];

    assign w_prodNeg = -r_acc;
    assign w_quotNeg = -r_acc[W-1:0];
    assign w_remNeg  = -r_acc[2*W-1:W];

    assign o_busy  = r_busy;
    assign o_hi    = r_hi;
    assign o_lo    = r_lo;
    assign o_stall = ~i_flush & (r_busy | ((r_state == IDLE) & i_start & (w_isMul | w_isDiv)));

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state   <= IDLE;
            r_busy    <= 1'b0;
            r_cnt     <= '0;
            r_hi      <= '0;
            r_lo      <= '0;
            r_mcand   <= '0;
            r_opB     <= '0;
            r_acc     <= '0;
            r_qSign   <= 1'b0;
            r_rSign   <= 1'b0;
            r_isDiv   <= 1'b0;
            r_divZero <= 1'b0;
        end else if (i_flush) begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (i_start) begin
                        if (i_funct == F_MTHI) begin
                            r_hi <= i_a;
                        end else if (i_funct == F_MTLO) begin
                            r_lo <= i_a;
                        end else if (w_isMul) begin
                            r_mcand   <= {{W{1'b0}}, w_aMag};
                            r_opB     <= w_bMag;
                            r_acc     <= '0;
                            r_qSign   <= w_aNeg ^ w_bNeg;
                            r_isDiv   <= 1'b0;
                            r_divZero <= 1'b0;
                            r_cnt     <= '0;
                            r_state   <= MUL;
                            r_busy    <= 1'b1;
                        end else if (w_isDiv) begin
                            r_isDiv <= 1'b1;
                            r_cnt   <= '0;
                            if (i_b == '0) begin
                                r_divZero <= 1'b1;
                                r_state   <= DONE;
                            end else begin
                                r_divZero <= 1'b0;
                                r_opB     <= w_bMag;
                                r_acc     <= {{W{1'b0}}, w_aMag};
                                r_qSign   <= w_aNeg ^ w_bNeg;
                                r_rSign   <= w_aNeg;
                                r_state   <= DIV;
                                r_busy    <= 1'b1;
                            end
                        end
                    end
                end
                MUL: begin
                    if (r_opB[0]) begin
                        r_acc <= r_acc + r_mcand;
                    end
                    r_mcand <= r_mcand << 1;
                    r_opB   <= r_opB >> 1;
                    r_cnt   <= r_cnt + CW'(1);
                    if (w_cntLast) begin
                        r_cnt   <= '0;
                        r_state <= DONE;
                        r_busy  <= 1'b0;
                    end
                end
                DIV: begin
                    r_acc <= {(w_fits ? w_diff[W-1:0] : w_remShift[W-1:0]), r_acc[W-2:0], w_fits};
                    r_cnt <= r_cnt + CW'(1);
                    if (w_cntLast) begin
                        r_cnt   <= '0;
                        r_state <= DONE;
                        r_busy  <= 1'b0;
                    end
                end
                DONE: begin
                    // A zero divisor leaves HI/LO untouched; start is ignored here.
                    if (!r_divZero) begin
                        if (r_isDiv) begin
                            r_lo <= r_qSign ? w_quotNeg : r_acc[W-1:0];
                            r_hi <= r_rSign ? w_remNeg  : r_acc[2*W-1:W];
                        end else begin
                            {r_hi, r_lo} <= r_qSign ? w_prodNeg : r_acc;
                        end
                    end
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mdu_ctrl.sv
// Self-checking bench for mdu_ctrl: table of ops with expected HI/LO/stall length, plus
// hand-written flush and asynchronous-reset sequences.
module tb_mdu_ctrl;

    localparam int W = 32;

    localparam logic [5:0] F_MULT  = 6'b011000;
    localparam logic [5:0] F_MULTU = 6'b011001;
    localparam logic [5:0] F_DIV   = 6'b011010;
    localparam logic [5:0] F_DIVU  = 6'b011011;
    localparam logic [5:0] F_MTHI  = 6'b010001;
    localparam logic [5:0] F_MTLO  = 6'b010011;

    typedef struct {
        logic [5:0]   funct;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] expHi;
        logic [W-1:0] expLo;
        int           expStall;
    } vec_t;

    typedef struct {
        logic [W-1:0] hi;
        logic [W-1:0] lo;
        int           stallCycles;
    } exp_t;

    logic         clk;
    logic         rst;
    logic         start;
    logic [5:0]   funct;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         flush;
    logic         stall;
    logic         busy;
    logic [W-1:0] hi;
    logic [W-1:0] lo;

    int   testCount;
    int   failCount;
    vec_t vecs[16];
    exp_t expQ[$];

    mdu_ctrl #(.W(W)) dut (
        .i_clk   (clk),
        .i_rst   (rst),
        .i_start (start),
        .i_funct (funct),
        .i_a     (a),
        .i_b     (b),
        .i_flush (flush),
        .o_stall (stall),
        .o_busy  (busy),
        .o_hi    (hi),
        .o_lo    (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkVal(input string name, input logic [63:0] actual, input logic [63:0] expected);
        testCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    task automatic checkOutput(input string name, input int stallCycles);
        exp_t e;
        if (expQ.size() == 0) begin
            testCount++;
            failCount++;
            $display("[TB] FAIL %s: scoreboard empty, got 0 entries, expected 1", name);
            return;
        end
        e = expQ.pop_front();
        checkVal({name, ".hi"}, 64'(hi), 64'(e.hi));
        checkVal({name, ".lo"}, 64'(lo), 64'(e.lo));
        checkVal({name, ".stallCycles"}, 64'(stallCycles), 64'(e.stallCycles));
        checkVal({name, ".busyAfter"}, 64'(busy), 64'(0));
    endtask

    // Holds start while stalled, as the pipeline would, then drops it after the retiring edge.
    task automatic applyStimulus(input string name, input logic [5:0] f, input logic [W-1:0] opA,
                                 input logic [W-1:0] opB, input logic [W-1:0] eHi,
                                 input logic [W-1:0] eLo, input int eStall);
        int stallCnt;
        @(negedge clk);
        start = 1'b1;
        funct = f;
        a     = opA;
        b     = opB;
        expQ.push_back('{hi: eHi, lo: eLo, stallCycles: eStall});
        stallCnt = 0;
        #1;
        while (stall && stallCnt < 100) begin
            stallCnt++;
            @(negedge clk);
            #1;
        end
        @(negedge clk);
        start = 1'b0;
        #1;
        checkOutput(name, stallCnt);
    endtask

    initial begin
        testCount = 0;
        failCount = 0;
        rst   = 1'b1;
        start = 1'b0;
        funct = '0;
        a     = '0;
        b     = '0;
        flush = 1'b0;

        vecs[0]  = '{F_MULTU, 32'hFFFFFFFF, 32'h00000002, 32'h00000001, 32'hFFFFFFFE, 33};
        vecs[1]  = '{F_MULT,  32'hFFFFFFFD, 32'h00000005, 32'hFFFFFFFF, 32'hFFFFFFF1, 33};
        vecs[2]  = '{F_DIVU,  32'd100,      32'd7,        32'd2,        32'd14,       33};
        vecs[3]  = '{F_DIV,   32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 33};
        vecs[4]  = '{F_DIV,   32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 33};
        vecs[5]  = '{F_MTHI,  32'h00001234, 32'h0,        32'h00001234, 32'hFFFFFFFD, 0};
        vecs[6]  = '{F_MTLO,  32'h00005678, 32'h0,        32'h00001234, 32'h00005678, 0};
        vecs[7]  = '{F_DIVU,  32'd9,        32'd0,        32'h00001234, 32'h00005678, 1};
        vecs[8]  = '{F_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 33};
        vecs[9]  = '{F_MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 33};
        vecs[10] = '{F_MULT,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000001, 33};
        vecs[11] = '{F_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 33};
        vecs[12] = '{F_DIV,   32'hFFFFFFF8, 32'hFFFFFFFD, 32'hFFFFFFFE, 32'h00000002, 33};
        vecs[13] = '{6'b100000, 32'h1,      32'h1,        32'hFFFFFFFE, 32'h00000002, 0};
        vecs[14] = '{F_DIV,   32'h00000005, 32'h0,        32'hFFFFFFFE, 32'h00000002, 1};
        vecs[15] = '{F_MULTU, 32'h00000000, 32'h00012345, 32'h00000000, 32'h00000000, 33};

        #12;
        rst = 1'b0;
        @(negedge clk);
        #1;
        checkVal("reset.hi", 64'(hi), 64'(0));
        checkVal("reset.lo", 64'(lo), 64'(0));
        checkVal("reset.busy", 64'(busy), 64'(0));
        checkVal("reset.stall", 64'(stall), 64'(0));

        for (int i = 0; i < 16; i++) begin
            applyStimulus($sformatf("vec%0d", i), vecs[i].funct, vecs[i].a, vecs[i].b,
                          vecs[i].expHi, vecs[i].expLo, vecs[i].expStall);
        end

        // Flush a signed multiply in iteration 10; HI/LO keep the values from vec15.
        @(negedge clk);
        start = 1'b1;
        funct = F_MULT;
        a     = 32'd5;
        b     = 32'd6;
        repeat (11) @(negedge clk);
        flush = 1'b1;
        #1;
        checkVal("flushMul.stall", 64'(stall), 64'(0));
        checkVal("flushMul.busyDuring", 64'(busy), 64'(1));
        @(negedge clk);
        flush = 1'b0;
        start = 1'b0;
        #1;
        checkVal("flushMul.busyAfter", 64'(busy), 64'(0));
        checkVal("flushMul.hi", 64'(hi), 64'(0));
        checkVal("flushMul.lo", 64'(lo), 64'(0));
        applyStimulus("afterFlush", F_MULTU, 32'd3, 32'd4, 32'd0, 32'd12, 33);

        // Flush in IDLE suppresses both a move and a multiply start.
        @(negedge clk);
        flush = 1'b1;
        start = 1'b1;
        funct = F_MTHI;
        a     = 32'hDEAD0000;
        #1;
        checkVal("flushIdleMthi.stall", 64'(stall), 64'(0));
        @(negedge clk);
        funct = F_MULT;
        #1;
        checkVal("flushIdleMult.stall", 64'(stall), 64'(0));
        @(negedge clk);
        flush = 1'b0;
        start = 1'b0;
        #1;
        checkVal("flushIdle.hi", 64'(hi), 64'(0));
        checkVal("flushIdle.busy", 64'(busy), 64'(0));

        // Asynchronous reset mid-divide, away from any clock edge.
        @(negedge clk);
        start = 1'b1;
        funct = F_DIVU;
        a     = 32'd100;
        b     = 32'd7;
        repeat (5) @(negedge clk);
        #1;
        checkVal("asyncRst.busyBefore", 64'(busy), 64'(1));
        #1;
        start = 1'b0;
        rst   = 1'b1;
        #1;
        checkVal("asyncRst.hi", 64'(hi), 64'(0));
        checkVal("asyncRst.lo", 64'(lo), 64'(0));
        checkVal("asyncRst.busy", 64'(busy), 64'(0));
        checkVal("asyncRst.stall", 64'(stall), 64'(0));
        #1;
        rst = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        checkVal("asyncRst.busyLater", 64'(busy), 64'(0));
        checkVal("asyncRst.loLater", 64'(lo), 64'(0));

        checkVal("scoreboard.empty", 64'(expQ.size()), 64'(0));

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule
